// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-input stream multiplexer with fixed-priority or
// round-robin arbitration, optional forced channel select, and a
// one-entry registered output stage with valid/ready handshaking.
module stream_mux_rr #(
  parameter int W    = 32,
  parameter int N    = 4,
  parameter int MODE = 1,
  localparam int CW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  input  logic           sel_en,
  input  logic [CW-1:0]  sel,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [CW-1:0]  out_ch,
  input  logic           out_ready
);

  logic           load_p0;
  logic [N-1:0]   elig_p0;
  logic [N-1:0]   grant_p0;
  logic           gvld_p0;
  logic [CW-1:0]  gidx_p0;
  logic [W-1:0]   gdata_p0;
  logic [CW-1:0]  ptr;

  // Stage p0: combinational eligibility, arbitration and handshake
  assign load_p0 = !out_valid || out_ready;

  // Eligible set: all valid channels, or only the forced channel when in range
  always_comb begin
    elig_p0 = in_valid;
    if (sel_en) begin
      elig_p0 = '0;
      if (32'(sel) < 32'(N)) elig_p0[sel] = in_valid[sel];
    end
  end

  // Pick the first eligible channel, scanning from 0 (fixed) or from ptr (round-robin)
  always_comb begin
    int          idx;
    logic [CW-1:0] idx_c;
    gvld_p0  = 1'b0;
    gidx_p0  = '0;
    gdata_p0 = '0;
    grant_p0 = '0;
    for (int k = 0; k < N; k++) begin
      idx = (MODE == 1) ? int'(ptr) + k : k;
      if (idx >= N) idx = idx - N;
      idx_c = CW'(idx);
      if (!gvld_p0 && elig_p0[idx_c]) begin
        gvld_p0  = 1'b1;
        gidx_p0  = idx_c;
        gdata_p0 = in_data[idx_c*W +: W];
      end
    end
    if (gvld_p0) grant_p0[gidx_p0] = 1'b1;
  end

  // Ready only to the granted channel, and only when the output register can take a word
  assign in_ready = (load_p0 && !rst) ? grant_p0 : '0;

  // Stage p1: output register and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (load_p0) begin
      if (gvld_p0) begin
        out_valid <= 1'b1;
        out_data  <= gdata_p0;
        out_ch    <= gidx_p0;
        if (MODE == 1)
          ptr <= (32'(gidx_p0) == 32'(N - 1)) ? '0 : gidx_p0 + 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr. Two instances: a 4-channel round-robin mux and a
// 5-channel fixed-priority mux (5 channels make sel=5 representable and out of range).
// A behavioural model predicts grants at each falling edge and queues the word
// expected to load on the next rising edge; held words are compared against the queue head.
module tb_stream_mux_rr;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Round-robin instance, N=4
  logic [3:0]   rr_valid, rr_ready;
  logic [127:0] rr_data;
  logic         rr_sel_en;
  logic [1:0]   rr_sel;
  logic         rr_ovld, rr_oready;
  logic [31:0]  rr_odata;
  logic [1:0]   rr_och;

  // Fixed-priority instance, N=5
  logic [4:0]   fp_valid, fp_ready;
  logic [159:0] fp_data;
  logic         fp_sel_en;
  logic [2:0]   fp_sel;
  logic         fp_ovld, fp_oready;
  logic [31:0]  fp_odata;
  logic [2:0]   fp_och;

  stream_mux_rr #(.W(32), .N(4), .MODE(1)) dut_rr (
    .clk(clk), .rst(rst), .in_valid(rr_valid), .in_data(rr_data), .in_ready(rr_ready),
    .sel_en(rr_sel_en), .sel(rr_sel), .out_valid(rr_ovld), .out_data(rr_odata),
    .out_ch(rr_och), .out_ready(rr_oready)
  );

  stream_mux_rr #(.W(32), .N(5), .MODE(0)) dut_fp (
    .clk(clk), .rst(rst), .in_valid(fp_valid), .in_data(fp_data), .in_ready(fp_ready),
    .sel_en(fp_sel_en), .sel(fp_sel), .out_valid(fp_ovld), .out_data(fp_odata),
    .out_ch(fp_och), .out_ready(fp_oready)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference grant: returns channel index or -1
  function automatic int pick(input logic [15:0] v, input logic se, input int s,
                              input int p, input int n, input int mode);
    int idx;
    if (se) return (s < n && v[s]) ? s : -1;
    for (int k = 0; k < n; k++) begin
      idx = (mode == 1) ? (p + k) % n : k;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  logic [63:0] rr_q[$];
  logic [63:0] fp_q[$];
  logic rr_mv = 1'b0, fp_mv = 1'b0;
  int   rr_mp = 0, fp_mp = 0;

  task automatic clear_models();
    rr_q.delete(); fp_q.delete();
    rr_mv = 1'b0; fp_mv = 1'b0;
    rr_mp = 0;    fp_mp = 0;
  endtask

  // Round-robin scoreboard
  always @(negedge clk) begin
    int g;
    logic load;
    logic [15:0] er;
    if (rst) begin
      check("rr_ready_in_rst", 64'(rr_ready), 64'd0);
    end else begin
      check("rr_out_valid", 64'(rr_ovld), 64'(rr_mv));
      if (rr_ovld) begin
        if (rr_q.size() == 0) check("rr_queue_depth", 64'(rr_q.size()), 64'd1);
        else begin
          check("rr_word", {32'(rr_och), rr_odata}, rr_q[0]);
          if (rr_oready) void'(rr_q.pop_front());
        end
      end
      load = !rr_mv || rr_oready;
      g = pick(16'(rr_valid), rr_sel_en, int'(rr_sel), rr_mp, 4, 1);
      er = '0;
      if (load && g >= 0) er[g] = 1'b1;
      check("rr_in_ready", 64'(rr_ready), 64'(er));
      if (load) begin
        if (g >= 0) begin
          rr_q.push_back({32'(g), rr_data[g*32 +: 32]});
          rr_mv = 1'b1;
          rr_mp = (g + 1) % 4;
        end else rr_mv = 1'b0;
      end
    end
  end

  // Fixed-priority scoreboard
  always @(negedge clk) begin
    int g;
    logic load;
    logic [15:0] er;
    if (rst) begin
      check("fp_ready_in_rst", 64'(fp_ready), 64'd0);
    end else begin
      check("fp_out_valid", 64'(fp_ovld), 64'(fp_mv));
      if (fp_ovld) begin
        if (fp_q.size() == 0) check("fp_queue_depth", 64'(fp_q.size()), 64'd1);
        else begin
          check("fp_word", {32'(fp_och), fp_odata}, fp_q[0]);
          if (fp_oready) void'(fp_q.pop_front());
        end
      end
      load = !fp_mv || fp_oready;
      g = pick(16'(fp_valid), fp_sel_en, int'(fp_sel), fp_mp, 5, 0);
      er = '0;
      if (load && g >= 0) er[g] = 1'b1;
      check("fp_in_ready", 64'(fp_ready), 64'(er));
      if (load) begin
        if (g >= 0) begin
          fp_q.push_back({32'(g), fp_data[g*32 +: 32]});
          fp_mv = 1'b1;
        end else fp_mv = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [127:0] rr_apat;

  initial begin
    rst = 1'b1;
    rr_valid = '0; rr_data = '0; rr_sel_en = 1'b0; rr_sel = '0; rr_oready = 1'b0;
    fp_valid = '0; fp_data = '0; fp_sel_en = 1'b0; fp_sel = '0; fp_oready = 1'b0;
    rr_apat = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    repeat (2) step();

    // Reset state; in_ready held low even with requests pending
    rr_valid = 4'hF; rr_data = rr_apat; rr_oready = 1'b1;
    #1;
    check("rst_out_valid", 64'(rr_ovld), 64'd0);
    check("rst_out_data", 64'(rr_odata), 64'd0);
    check("rst_out_ch", 64'(rr_och), 64'd0);
    check("rst_in_ready", 64'(rr_ready), 64'd0);
    check("rst_fp_out_valid", 64'(fp_ovld), 64'd0);
    rst = 1'b0;

    // Round-robin rotation over all four channels, then wrap
    for (int k = 0; k < 5; k++) begin
      step();
      check("rr_seq_ch", 64'(rr_och), 64'(k % 4));
      check("rr_seq_data", 64'(rr_odata), 64'(32'hA0 + (k % 4)));
    end

    // Backpressure: word from ch2 held while out_ready is low
    rr_sel_en = 1'b1; rr_sel = 2'd2; rr_valid = 4'b0100;
    rr_data = {32'h0, 32'h12345678, 32'h0, 32'h0};
    step();
    check("bp_load_ch", 64'(rr_och), 64'd2);
    rr_sel_en = 1'b0; rr_oready = 1'b0; rr_valid = 4'b0001;
    rr_data = {32'h0, 32'h0, 32'h0, 32'hCAFE0000};
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_in_ready", 64'(rr_ready), 64'd0);
      step();
      check("bp_hold_data", 64'(rr_odata), 64'h12345678);
    end
    rr_oready = 1'b1;
    step();
    check("bp_release_ch", 64'(rr_och), 64'd0);
    check("bp_release_data", 64'(rr_odata), 64'hCAFE0000);

    // Forced select of ch3 with all channels requesting
    rr_sel_en = 1'b1; rr_sel = 2'd3; rr_valid = 4'hF; rr_data = rr_apat;
    #1;
    check("force3_in_ready", 64'(rr_ready), 64'b1000);
    step();
    check("force3_ch", 64'(rr_och), 64'd3);
    step();
    check("force3_ch_again", 64'(rr_och), 64'd3);
    rr_sel_en = 1'b0; rr_valid = '0;
    step();
    check("force3_drained", 64'(rr_ovld), 64'd0);

    // Fixed priority: ch1 always wins over ch3
    fp_oready = 1'b1; fp_valid = 5'b01010;
    for (int i = 0; i < 5; i++) fp_data[i*32 +: 32] = 32'hB0 + i;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("fp_only_ch1_ready", 64'(fp_ready), 64'b00010);
      step();
      check("fp_ch", 64'(fp_och), 64'd1);
      check("fp_data", 64'(fp_odata), 64'hB1);
    end

    // Out-of-range forced select: no grant, register drains
    fp_sel_en = 1'b1; fp_sel = 3'd5; fp_valid = 5'b11111;
    #1;
    check("badsel_in_ready", 64'(fp_ready), 64'd0);
    step();
    check("badsel_out_valid", 64'(fp_ovld), 64'd0);
    fp_sel_en = 1'b0; fp_valid = '0;

    // Random traffic on both instances
    for (int c = 0; c < 400; c++) begin
      rr_valid  = 4'($urandom);
      rr_data   = {$urandom, $urandom, $urandom, $urandom};
      rr_oready = ($urandom_range(0, 3) != 0);
      rr_sel_en = ($urandom_range(0, 4) == 0);
      rr_sel    = 2'($urandom_range(0, 3));
      fp_valid  = 5'($urandom);
      fp_data   = {$urandom, $urandom, $urandom, $urandom, $urandom};
      fp_oready = ($urandom_range(0, 3) != 0);
      fp_sel_en = ($urandom_range(0, 4) == 0);
      fp_sel    = 3'($urandom_range(0, 7));
      step();
    end

    // Asynchronous reset mid-stream with ptr at 2
    fp_valid = '0; fp_sel_en = 1'b0; fp_oready = 1'b1;
    rr_sel_en = 1'b0; rr_oready = 1'b1; rr_valid = 4'b0010; rr_data = rr_apat;
    step();
    check("pre_rst_ch", 64'(rr_och), 64'd1);
    rr_oready = 1'b0; rr_valid = 4'hF;
    #1;
    rst = 1'b1;
    clear_models();
    #1;
    check("async_rst_valid", 64'(rr_ovld), 64'd0);
    check("async_rst_data", 64'(rr_odata), 64'd0);
    check("async_rst_ch", 64'(rr_och), 64'd0);
    rst = 1'b0;
    rr_oready = 1'b1;
    step();
    check("post_rst_ch", 64'(rr_och), 64'd0);
    check("post_rst_data", 64'(rr_odata), 64'hA0);

    // Drain everything and confirm nothing was lost or duplicated
    rr_valid = '0; fp_valid = '0; rr_oready = 1'b1; fp_oready = 1'b1;
    repeat (3) step();
    check("rr_queue_empty", 64'(rr_q.size()), 64'd0);
    check("fp_queue_empty", 64'(fp_q.size()), 64'd0);
    check("rr_idle", 64'(rr_ovld), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
